dpram_rd_arbiter: RTL and testbench

Round-robin arbiter that shares the single read port of the two-write-port DPRAM between two independent requesters.
- Issues one read at a time to the RAM.
- Tracks which requester owns the in-flight response.
- Routes RDATA/RVALID back to that owner and forwards the owner's RREADY to the RAM.
- Sits between the buffet read-side logic (fill/drain consumers) and the RAM. The write ports are not touched.

---
 rtl/dpram_rd_arbiter.sv | 104 ++++++++++
 tb/tb_dpram_rd_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_rd_arbiter.sv
// Two-requester arbiter in front of the single DPRAM read port: one read in flight at a time,
// response routed back to whichever requester issued it.
module dpram_rd_arbiter #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned RR_EN      = 1
) (
  input  logic                  CLK,
  input  logic                  RESET,

  input  logic                  ARVALID0,
  input  logic [ADDR_WIDTH-1:0] ARADDR0,
  output logic                  ARREADY0,
  output logic                  RVALID0,
  output logic [DATA_WIDTH-1:0] RDATA0,
  input  logic                  RREADY0,

  input  logic                  ARVALID1,
  input  logic [ADDR_WIDTH-1:0] ARADDR1,
  output logic                  ARREADY1,
  output logic                  RVALID1,
  output logic [DATA_WIDTH-1:0] RDATA1,
  input  logic                  RREADY1,

  output logic                  RAM_ARVALID,
  output logic [ADDR_WIDTH-1:0] RAM_ARADDR,
  input  logic                  RAM_RVALID,
  input  logic [DATA_WIDTH-1:0] RAM_RDATA,
  output logic                  RAM_RREADY
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_grant_q, last_grant_d;

  logic busy;
  logic owner_rready;
  logic ram_rready;
  logic can_issue;
  logic gnt_valid;
  logic gnt_id;

  always_comb begin
    busy         = (state_q == StBusy);
    owner_rready = owner_q ? RREADY1 : RREADY0;
    ram_rready   = busy & RAM_RVALID & owner_rready;
    // Issuing while the current response is consumed keeps one read per cycle; the RAM
    // only overwrites its data register after the old response has been taken.
    can_issue    = RESET & (~busy | ram_rready);
    gnt_valid    = can_issue & (ARVALID0 | ARVALID1);
    if (ARVALID0 & ARVALID1) begin
      gnt_id = (RR_EN != 0) ? ~last_grant_q : 1'b0;
    end else begin
      gnt_id = ARVALID1;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    if (gnt_valid) begin
      state_d      = StBusy;
      owner_d      = gnt_id;
      last_grant_d = gnt_id;
    end else if (ram_rready) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    ARREADY0    = gnt_valid & ~gnt_id;
    ARREADY1    = gnt_valid & gnt_id;
    RAM_ARVALID = gnt_valid;
    // Address is forced to 0 while reset is held so every output reads 0.
    if (!RESET) begin
      RAM_ARADDR = '0;
    end else if (gnt_valid & gnt_id) begin
      RAM_ARADDR = ARADDR1;
    end else begin
      RAM_ARADDR = ARADDR0;
    end
    RAM_RREADY = ram_rready;
    RVALID0    = busy & ~owner_q & RAM_RVALID;
    RVALID1    = busy & owner_q & RAM_RVALID;
    RDATA0     = (busy & ~owner_q) ? RAM_RDATA : '0;
    RDATA1     = (busy & owner_q) ? RAM_RDATA : '0;
  end

endmodule

// File: tb/tb_dpram_rd_arbiter.sv
// Directed bench for dpram_rd_arbiter: table of per-cycle vectors plus hand-written sequences
// for glitch, mid-read reset and fixed-priority behaviour.
module tb_dpram_rd_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arv0 = 1'b0, arv1 = 1'b0, rr0 = 1'b0, rr1 = 1'b0;
  logic [AW-1:0] a0 = '0, a1 = '0;
  logic          glitch = 1'b0;

  // Round-robin instance
  logic          ar0, ar1, rv0, rv1, ram_arv, ram_rrdy;
  logic [DW-1:0] rd0, rd1;
  logic [AW-1:0] ram_addr;
  logic          ram_rv_q = 1'b0;
  logic [DW-1:0] ram_rd_q = '0;

  // Fixed-priority instance
  logic          f_ar0, f_ar1, f_rv0, f_rv1, f_ram_arv, f_ram_rrdy;
  logic [DW-1:0] f_rd0, f_rd1;
  logic [AW-1:0] f_ram_addr;
  logic          f_ram_rv_q = 1'b0;
  logic [DW-1:0] f_ram_rd_q = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    if (a == 10'd5) return 64'hA5;
    return {32'hC0DE_0000, 22'h0, a};
  endfunction

  // RAM models: data one cycle after issue, valid sticky until consumed, not reset.
  always @(posedge clk) begin
    if (ram_arv) begin
      ram_rd_q <= mem_val(ram_addr);
      ram_rv_q <= 1'b1;
    end else if (ram_rrdy) begin
      ram_rv_q <= 1'b0;
    end
    if (f_ram_arv) begin
      f_ram_rd_q <= mem_val(f_ram_addr);
      f_ram_rv_q <= 1'b1;
    end else if (f_ram_rrdy) begin
      f_ram_rv_q <= 1'b0;
    end
  end

  dpram_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_EN(1)) dut (
    .CLK(clk), .RESET(rst_n),
    .ARVALID0(arv0), .ARADDR0(a0), .ARREADY0(ar0), .RVALID0(rv0), .RDATA0(rd0), .RREADY0(rr0),
    .ARVALID1(arv1), .ARADDR1(a1), .ARREADY1(ar1), .RVALID1(rv1), .RDATA1(rd1), .RREADY1(rr1),
    .RAM_ARVALID(ram_arv), .RAM_ARADDR(ram_addr), .RAM_RVALID(ram_rv_q | glitch),
    .RAM_RDATA(ram_rd_q), .RAM_RREADY(ram_rrdy)
  );

  dpram_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_EN(0)) dut_fp (
    .CLK(clk), .RESET(rst_n),
    .ARVALID0(arv0), .ARADDR0(a0), .ARREADY0(f_ar0), .RVALID0(f_rv0), .RDATA0(f_rd0),
    .RREADY0(rr0),
    .ARVALID1(arv1), .ARADDR1(a1), .ARREADY1(f_ar1), .RVALID1(f_rv1), .RDATA1(f_rd1),
    .RREADY1(rr1),
    .RAM_ARVALID(f_ram_arv), .RAM_ARADDR(f_ram_addr), .RAM_RVALID(f_ram_rv_q),
    .RAM_RDATA(f_ram_rd_q), .RAM_RREADY(f_ram_rrdy)
  );

  typedef struct {
    logic          v0;
    logic [AW-1:0] a0;
    logic          v1;
    logic [AW-1:0] a1;
    logic          r0;
    logic          r1;
    logic          e_ar0;
    logic          e_ar1;
    logic          e_rav;
    logic [AW-1:0] e_raddr;
    logic          e_rrdy;
    logic          e_rv0;
    logic          e_rv1;
    logic [DW-1:0] e_rd0;
    logic [DW-1:0] e_rd1;
  } vec_t;

  function automatic vec_t mk(input logic v0, input logic [AW-1:0] a0, input logic v1,
                              input logic [AW-1:0] a1, input logic r0, input logic r1,
                              input logic e_ar0, input logic e_ar1, input logic e_rav,
                              input logic [AW-1:0] e_raddr, input logic e_rrdy,
                              input logic e_rv0, input logic e_rv1,
                              input logic [DW-1:0] e_rd0, input logic [DW-1:0] e_rd1);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.v1 = v1; v.a1 = a1; v.r0 = r0; v.r1 = r1;
    v.e_ar0 = e_ar0; v.e_ar1 = e_ar1; v.e_rav = e_rav; v.e_raddr = e_raddr;
    v.e_rrdy = e_rrdy; v.e_rv0 = e_rv0; v.e_rv1 = e_rv1; v.e_rd0 = e_rd0; v.e_rd1 = e_rd1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [AW-1:0] ad0, input logic v1,
                       input logic [AW-1:0] ad1, input logic r0, input logic r1);
    arv0 = v0; a0 = ad0; arv1 = v1; a1 = ad1; rr0 = r0; rr1 = r1;
  endtask

  vec_t vecs[14];

  initial begin
    // Cycle-by-cycle after reset (last_grant=1 so requester 0 wins the first tie).
    vecs[0]  = mk(1, 10'h05, 0, 10'h00, 1, 1,  1, 0, 1, 10'h05, 0,  0, 0, 0, 0);
    vecs[1]  = mk(0, 10'h05, 0, 10'h00, 1, 1,  0, 0, 0, 10'h05, 1,  1, 0, mem_val(10'h05), 0);
    vecs[2]  = mk(1, 10'h10, 1, 10'h20, 1, 1,  0, 1, 1, 10'h20, 0,  0, 0, 0, 0);
    vecs[3]  = mk(1, 10'h10, 1, 10'h20, 1, 1,  1, 0, 1, 10'h10, 1,  0, 1, 0, mem_val(10'h20));
    vecs[4]  = mk(1, 10'h10, 1, 10'h20, 1, 1,  0, 1, 1, 10'h20, 1,  1, 0, mem_val(10'h10), 0);
    vecs[5]  = mk(1, 10'h30, 0, 10'h00, 1, 0,  0, 0, 0, 10'h30, 0,  0, 1, 0, mem_val(10'h20));
    vecs[6]  = mk(1, 10'h30, 0, 10'h00, 1, 0,  0, 0, 0, 10'h30, 0,  0, 1, 0, mem_val(10'h20));
    vecs[7]  = mk(1, 10'h30, 0, 10'h00, 1, 0,  0, 0, 0, 10'h30, 0,  0, 1, 0, mem_val(10'h20));
    vecs[8]  = mk(1, 10'h30, 0, 10'h00, 1, 1,  1, 0, 1, 10'h30, 1,  0, 1, 0, mem_val(10'h20));
    vecs[9]  = mk(0, 10'h30, 0, 10'h00, 1, 1,  0, 0, 0, 10'h30, 1,  1, 0, mem_val(10'h30), 0);
    vecs[10] = mk(1, 10'h07, 0, 10'h00, 0, 0,  1, 0, 1, 10'h07, 0,  0, 0, 0, 0);
    vecs[11] = mk(0, 10'h07, 0, 10'h00, 0, 0,  0, 0, 0, 10'h07, 0,  1, 0, mem_val(10'h07), 0);
    vecs[12] = mk(0, 10'h07, 0, 10'h00, 1, 0,  0, 0, 0, 10'h07, 1,  1, 0, mem_val(10'h07), 0);
    vecs[13] = mk(0, 10'h07, 0, 10'h00, 1, 1,  0, 0, 0, 10'h07, 0,  0, 0, 0, 0);

    // Reset held with a request pending: everything must read 0.
    drive(1, 10'h05, 1, 10'h20, 1, 1);
    #12;
    chk("rst arready0", ar0, 0);
    chk("rst arready1", ar1, 0);
    chk("rst ram_arvalid", ram_arv, 0);
    chk("rst ram_araddr", ram_addr, 0);
    chk("rst rvalid0", rv0, 0);
    chk("rst rvalid1", rv1, 0);
    @(negedge clk);
    drive(0, 10'h00, 0, 10'h00, 1, 1);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vecs[i].v0, vecs[i].a0, vecs[i].v1, vecs[i].a1, vecs[i].r0, vecs[i].r1);
      #2;
      chk($sformatf("v%0d arready0", i), ar0, vecs[i].e_ar0);
      chk($sformatf("v%0d arready1", i), ar1, vecs[i].e_ar1);
      chk($sformatf("v%0d ram_arvalid", i), ram_arv, vecs[i].e_rav);
      chk($sformatf("v%0d ram_araddr", i), ram_addr, vecs[i].e_raddr);
      chk($sformatf("v%0d ram_rready", i), ram_rrdy, vecs[i].e_rrdy);
      chk($sformatf("v%0d rvalid0", i), rv0, vecs[i].e_rv0);
      chk($sformatf("v%0d rvalid1", i), rv1, vecs[i].e_rv1);
      chk($sformatf("v%0d rdata0", i), rd0, vecs[i].e_rd0);
      chk($sformatf("v%0d rdata1", i), rd1, vecs[i].e_rd1);
    end

    // Spurious RAM_RVALID while idle is ignored.
    @(negedge clk);
    drive(0, 10'h00, 0, 10'h00, 1, 1);
    glitch = 1'b1;
    #2;
    chk("glitch rvalid0", rv0, 0);
    chk("glitch rvalid1", rv1, 0);
    chk("glitch ram_rready", ram_rrdy, 0);
    @(negedge clk);
    glitch = 1'b0;
    #2;
    chk("post-glitch rvalid0", rv0, 0);

    // Reset one cycle after a grant, with the response pending in the RAM.
    @(negedge clk);
    drive(1, 10'h05, 0, 10'h00, 0, 0);
    #2;
    chk("pre-rst grant", ar0, 1);
    @(negedge clk);
    drive(0, 10'h05, 1, 10'h20, 0, 0);
    #2;
    chk("pre-rst rvalid0", rv0, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst arready0", ar0, 0);
    chk("midrst arready1", ar1, 0);
    chk("midrst ram_arvalid", ram_arv, 0);
    chk("midrst ram_araddr", ram_addr, 0);
    chk("midrst rvalid0", rv0, 0);
    chk("midrst rvalid1", rv1, 0);
    chk("midrst rdata0", rd0, 0);
    chk("midrst ram_rready", ram_rrdy, 0);
    @(negedge clk);
    drive(0, 10'h00, 0, 10'h00, 1, 1);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2;
      chk($sformatf("postrst%0d rvalid0", i), rv0, 0);
      chk($sformatf("postrst%0d rvalid1", i), rv1, 0);
      chk($sformatf("postrst%0d ram_rready", i), ram_rrdy, 0);
      @(negedge clk);
    end
    drive(0, 10'h00, 1, 10'h20, 1, 1);
    #2;
    chk("postrst grant1", ar1, 1);
    chk("postrst addr", ram_addr, 10'h20);
    @(negedge clk);
    drive(0, 10'h00, 0, 10'h00, 1, 1);
    #2;
    chk("postrst rvalid1", rv1, 1);
    chk("postrst rdata1", rd1, mem_val(10'h20));
    chk("postrst rvalid0", rv0, 0);

    // Fixed priority: drain both instances, then both requesters valid for 4 issues.
    @(negedge clk);
    @(negedge clk);
    drive(1, 10'h10, 1, 10'h20, 1, 1);
    for (int i = 0; i < 4; i++) begin
      #2;
      chk($sformatf("fp%0d arready0", i), f_ar0, 1);
      chk($sformatf("fp%0d arready1", i), f_ar1, 0);
      chk($sformatf("fp%0d ram_araddr", i), f_ram_addr, 10'h10);
      @(negedge clk);
    end
    drive(0, 10'h00, 0, 10'h00, 1, 1);
    #2;
    chk("fp rvalid0", f_rv0, 1);
    chk("fp rdata0", f_rd0, mem_val(10'h10));
    chk("fp rvalid1", f_rv1, 0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
